// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM state types plus the memory arbiter's
// FSM state and default requester index type.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } memarb_state_t;

    localparam int MEMARB_CPUS  = 2;
    localparam int MEMARB_IDX_W = $clog2(2 * MEMARB_CPUS);
    typedef logic [MEMARB_IDX_W-1:0] memarb_idx_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational requester selector: scans cores starting at ptr, dcache
// (even index) ahead of icache (odd index) within each core.
module mem_arbiter_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = MEMARB_CPUS,
    parameter int IDX_W = $clog2(2 * CPUS),
    parameter int CW    = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic [2*CPUS-1:0] req,
    input  logic [CW-1:0]     ptr,
    output logic              vld,
    output logic [IDX_W-1:0]  idx
);

    int c;

    always_comb begin
        vld = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = 0; k < CPUS; k++) begin
            c = (int'(ptr) + k) % CPUS;
            for (int j = 0; j < CPUS; j++) begin
                if (!vld && j == c) begin
                    if (req[2*j]) begin
                        vld = 1'b1;
                        idx = IDX_W'(2 * j);
                    end else if (req[2*j+1]) begin
                        vld = 1'b1;
                        idx = IDX_W'(2 * j + 1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises per-core icache/dcache requests onto one RAM port.
// Define MEM_ARBITER_RR_EN for round-robin across cores; default is fixed priority.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = MEMARB_CPUS
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);

    localparam int NREQ  = 2 * CPUS;
    localparam int IDX_W = $clog2(NREQ);
    localparam int CW    = (CPUS > 1) ? $clog2(CPUS) : 1;

    memarb_state_t    state, state_nxt;
    logic [IDX_W-1:0] grant, grant_nxt;
    logic [NREQ-1:0]  req;
    logic [CW-1:0]    ptr;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             live, ack;

    always_comb begin
        req = '0;
        for (int c = 0; c < CPUS; c++) begin
            req[2*c]   = dREN[c] | dWEN[c];
            req[2*c+1] = iREN[c];
        end
    end

    mem_arbiter_pick #(.CPUS(CPUS), .IDX_W(IDX_W), .CW(CW)) u_pick (
        .req (req),
        .ptr (ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

`ifdef MEM_ARBITER_RR_EN
    logic [CW-1:0] ptr_nxt;
    logic [CW-1:0] ack_core;

    assign ack_core = CW'(grant >> 1);
    assign ptr_nxt  = !ack ? ptr :
                      (ack_core == CW'(CPUS - 1)) ? '0 : ack_core + CW'(1);

    always_ff @(posedge CLK) begin
        if (!nRST) ptr <= '0;
        else       ptr <= ptr_nxt;
    end
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = '1;
        dwait     = '1;
        iload     = '0;
        dload     = '0;
        live      = 1'b0;
        ack       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    grant_nxt = pick_idx;
                end
            end
            GRANT: begin
                // RAM side follows the granted requester's live inputs, so an abort drops enables at once
                for (int c = 0; c < CPUS; c++) begin
                    if (grant == IDX_W'(2 * c)) begin
                        live = dREN[c] | dWEN[c];
                        if (live) begin
                            ramWEN   = dWEN[c];
                            ramREN   = ~dWEN[c];
                            ramaddr  = daddr[c];
                            ramstore = dstore[c];
                        end
                        if (live && ramstate == ACCESS) begin
                            ack      = 1'b1;
                            dwait[c] = 1'b0;
                            dload[c] = ramload;
                        end
                    end else if (grant == IDX_W'(2 * c + 1)) begin
                        live = iREN[c];
                        if (live) begin
                            ramREN  = 1'b1;
                            ramaddr = iaddr[c];
                        end
                        if (live && ramstate == ACCESS) begin
                            ack      = 1'b1;
                            iwait[c] = 1'b0;
                            iload[c] = ramload;
                        end
                    end
                end
                if (!live || ack) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// compared on every falling edge.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;

    logic                  CLK, nRST;
    logic [CPUS-1:0]       iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS-1:0][31:0] iaddr, daddr, dstore, iload, dload;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    logic [1:0]            ramstate;

    int checks = 0;
    int errors = 0;
    int ackq[$];
    bit started = 0;

    mem_arbiter #(.CPUS(CPUS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: which requester wins given the request set and first-priority core
    function automatic int pick(input int p);
        int c;
        for (int k = 0; k < CPUS; k++) begin
            c = (p + k) % CPUS;
            if (dREN[c] || dWEN[c]) return 2 * c;
            if (iREN[c])            return 2 * c + 1;
        end
        return -1;
    endfunction

    int owner = -1;
    int mptr  = 0;

    always @(negedge CLK) begin
        if (started) begin
            logic e_ren, e_wen, live, ack;
            logic [31:0] e_addr, e_store;
            logic [CPUS-1:0] e_iw, e_dw;
            logic [CPUS-1:0][31:0] e_il, e_dl;
            int core;
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
            e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
            live = 0; ack = 0; core = 0;
            if (owner >= 0) begin
                core = owner / 2;
                if (owner % 2 == 0) begin
                    live = dREN[core] | dWEN[core];
                    if (live) begin
                        e_wen = dWEN[core];
                        e_ren = dREN[core] & ~dWEN[core];
                        e_addr = daddr[core];
                        e_store = dstore[core];
                    end
                    ack = live && (ramstate == ACCESS);
                    if (ack) begin e_dw[core] = 1'b0; e_dl[core] = ramload; end
                end else begin
                    live = iREN[core];
                    if (live) begin e_ren = 1'b1; e_addr = iaddr[core]; end
                    ack = live && (ramstate == ACCESS);
                    if (ack) begin e_iw[core] = 1'b0; e_il[core] = ramload; end
                end
            end
            chk("ramREN", ramREN, e_ren);
            chk("ramWEN", ramWEN, e_wen);
            chk("ramaddr", ramaddr, e_addr);
            chk("ramstore", ramstore, e_store);
            chk("iwait", iwait, e_iw);
            chk("dwait", dwait, e_dw);
            for (int c = 0; c < CPUS; c++) begin
                chk("iload", iload[c], e_il[c]);
                chk("dload", dload[c], e_dl[c]);
                if (dwait[c] === 1'b0) ackq.push_back(c);
            end
            if (!nRST) begin
                owner = -1;
                mptr  = 0;
            end else if (owner < 0) begin
                owner = pick(mptr);
            end else if (!live || ack) begin
`ifdef MEM_ARBITER_RR_EN
                if (ack) mptr = (core + 1) % CPUS;
`endif
                owner = -1;
            end
        end
    end

    initial begin
        int exp_order[4];
`ifdef MEM_ARBITER_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        nRST = 0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;

        // reset
        @(posedge CLK); started = 1; #1;
        tick();
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_dwait", dwait, 2'b11);
        nRST = 1;
        tick();

        // single icache read, ACCESS on first driven cycle
        iREN[0] = 1; iaddr[0] = 32'h40; #1;
        chk("ird_req_cycle_ren", ramREN, 0);
        tick();
        ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        chk("ird_ren", ramREN, 1);
        chk("ird_addr", ramaddr, 32'h40);
        chk("ird_iwait", iwait[0], 0);
        chk("ird_iload", iload[0], 32'hDEADBEEF);
        tick();
        iREN = '0; ramstate = FREE; ramload = '0;
        tick();

        // same-core conflict: write beats instruction fetch
        iREN[0] = 1; iaddr[0] = 32'h44;
        dREN[0] = 1; dWEN[0] = 1; daddr[0] = 32'h80; dstore[0] = 32'h1234;
        tick();
        chk("conf_wen", ramWEN, 1);
        chk("conf_ren", ramREN, 0);
        chk("conf_store", ramstore, 32'h1234);
        chk("conf_addr", ramaddr, 32'h80);
        chk("conf_iwait", iwait[0], 1);
        ramstate = ACCESS; #1;
        chk("conf_dwait", dwait[0], 0);
        tick();
        dREN = '0; dWEN = '0; ramstate = FREE; #1;
        chk("conf_idle_iwait", iwait[0], 1);
        tick();
        ramstate = ACCESS; ramload = 32'h55; #1;
        chk("conf_iaddr", ramaddr, 32'h44);
        chk("conf_iload", iload[0], 32'h55);
        tick();
        iREN = '0; ramstate = FREE; ramload = '0;

        // cross-core contention from a fresh pointer
        nRST = 0;
        tick();
        nRST = 1;
        dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200;
        ramstate = ACCESS; ramload = 32'hA5A5A5A5;
        ackq.delete();
        repeat (8) tick();
        dREN = '0; ramstate = FREE; ramload = '0;
        chk("cont_count", ackq.size(), 4);
        for (int i = 0; i < 4 && i < ackq.size(); i++)
            chk("cont_order", ackq[i], exp_order[i]);
        tick();

        // ERROR retry holds the grant even with a new competitor
        dREN[1] = 1; daddr[1] = 32'h300; ramstate = ERROR; ramload = 32'h77;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("err_dwait", dwait[1], 1);
            chk("err_addr", ramaddr, 32'h300);
            if (i == 0) begin dREN[0] = 1; daddr[0] = 32'h100; end
            tick();
        end
        ramstate = ACCESS; #1;
        chk("err_ack", dwait[1], 0);
        chk("err_load", dload[1], 32'h77);
        tick();
        dREN = '0; ramstate = FREE; ramload = '0;
        tick();

        // abort mid-grant, then reset mid-grant
        dREN[0] = 1; daddr[0] = 32'h500; ramstate = BUSY;
        tick();
        chk("abt_ren_granted", ramREN, 1);
        dREN[0] = 0; iREN[1] = 1; iaddr[1] = 32'h600; #1;
        chk("abt_ren_drop", ramREN, 0);
        chk("abt_dwait", dwait, 2'b11);
        tick();
        chk("abt_idle_ren", ramREN, 0);
        tick();
        chk("abt_next_ren", ramREN, 1);
        chk("abt_next_addr", ramaddr, 32'h600);
        nRST = 0;
        tick();
        chk("rstg_ren", ramREN, 0);
        chk("rstg_addr", ramaddr, 0);
        chk("rstg_iwait", iwait, 2'b11);
        nRST = 1; iREN = '0; ramstate = FREE;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shared-memory arbiter directly downstream of the per-core instruction and data caches.
- Collects cache-side read/write requests from every core and serialises them onto the single RAM port.
- Returns per-requester wait signals and load data; the caches use these as their `iwait`/`dwait` handshake.
- Sits between the cache_control side of each core and the RAM model; holds each grant until RAM reports completion.

## Interface
- CPUS, default 2: number of cores. Each core contributes one icache and one dcache requester.
- CLK  in  1: sole clock; all state updates on the rising edge.
- nRST  in  1: reset, synchronous, active-low.
- iREN  in  CPUS: per-core instruction read request.
- iaddr  in  CPUS x 32: per-core instruction address (word_t).
- dREN  in  CPUS: per-core data read request.
- dWEN  in  CPUS: per-core data write request.
- daddr  in  CPUS x 32: per-core data address.
- dstore  in  CPUS x 32: per-core write data.
- iwait  out  CPUS: instruction request not yet completed.
- dwait  out  CPUS: data request not yet completed.
- iload  out  CPUS x 32: instruction read data.
- dload  out  CPUS x 32: data read data.
- ramREN  out  1: RAM read enable.
- ramWEN  out  1: RAM write enable.
- ramaddr  out  32: RAM address.
- ramstore  out  32: RAM write data.
- ramload  in  32: RAM read data.
- ramstate  in  2: ramstate_t, one of FREE, BUSY, ACCESS, ERROR.

## Operation
- There are 2*CPUS requesters. Requester index is core*2 + 0 for the dcache and core*2 + 1 for the icache.
- **Dcache request:** dREN|dWEN. If dWEN and dREN are both high, the request is a write; only ramWEN is driven.
- **Icache request:** iREN.
- **Priority within a core:** dcache over icache.
- **Priority across cores:** set by the selection policy in Configuration.
- **States:**
  - IDLE: no grant.
  - GRANT: a registered grant index is held.
- **IDLE → GRANT:** when any request is pending. The selected index is latched into the grant register.
- **In GRANT:**
  - ramREN/ramWEN, ramaddr and ramstore are driven combinationally from the granted requester's live inputs.
  - All other requesters see their ram data ignored and their wait held high.
- **GRANT → IDLE:**
  - when ramstate==ACCESS. In that same cycle the granted wait is 0 and its load equals ramload.
  - when the granted requester deasserts its request (abort). RAM enables drop in that cycle and nothing is acknowledged.
- **ramstate==ERROR:** the requester stays granted and its wait stays 1. The transaction retries until ACCESS or abort.
- **Wait outputs:** every wait is 1 except in the ACCESS cycle of the granted requester.
- **Load outputs:** every load is 0 except that acknowledged one.
- **A dcache block fill:** two separate word transactions. The arbiter re-arbitrates between the words; it does not lock the bus.
- **Outputs during reset and in IDLE:**
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - all iwait=1 and all dwait=1.
  - all iload=0 and all dload=0.
  - grant=0, state=IDLE.

## Timing
- A request sampled high in IDLE at edge n is driven to RAM starting cycle n+1.
- Minimum latency is request cycle + 1, with wait low in the first ACCESS cycle.
- After an acknowledge there is exactly one IDLE cycle before the next grant. The back-to-back minimum is 2 cycles per transaction.
- A requester must hold its request and address until it sees wait=0. On wait=0, the load data is valid only in that cycle.
- nRST low at any edge, including mid-transaction:
  - state is forced to IDLE and the grant cleared.
  - outputs take their reset values in the following cycle.
  - any in-flight RAM access is abandoned unacknowledged.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin across cores.
  - A pointer register (reset 0) names the highest-priority core.
  - On each acknowledge, the pointer becomes granted core + 1, mod CPUS.
  - Aborts do not move the pointer.
- MEM_ARBITER_RR_EN undefined: fixed priority, with the lowest core index winning. There is no pointer register.

## Structure
- **In cpu_types_pkg:**
  - word_t and ramstate_t (already present).
  - a new memarb_state_t {IDLE, GRANT}.
  - a localparam-friendly requester index type sized $clog2(2*CPUS).
- **Sub-module:** mem_arbiter_pick, a combinational selector.
  - Inputs: the request vector and the priority pointer.
  - Outputs: a valid flag and the selected index.
  - The pointer input is tied to 0 when round-robin is compiled out.

## Test plan
- **Reset:** nRST=0 for 2 cycles → ramREN=ramWEN=0 and all iwait/dwait=1.
- **Single icache read:** iREN[0]=1, iaddr=0x40, ramstate ACCESS on first driven cycle with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x40 at n+1; iwait[0]=0 and iload[0]=0xDEADBEEF in that cycle.
- **Same-core conflict:** iREN[0] and dWEN[0] together, daddr=0x80, dstore=0x1234 → the write is served first; ramWEN=1, ramstore=0x1234; iwait[0] stays 1 until a later grant.
- **Cross-core contention:** dREN[0] and dREN[1] held continuously for 4 transactions → with MEM_ARBITER_RR_EN the grant order is 0,1,0,1; without it, the grant order is 0,0,0,0.
- **ERROR retry:** ramstate ERROR for 3 cycles, then ACCESS → dwait stays 1 for 3 cycles, then 0 once; the grant does not change.
- **Abort and reset:** the requester drops dREN mid-grant → ramREN is 0 in that cycle and the next request is granted after one IDLE cycle. nRST asserted mid-GRANT → IDLE with reset outputs at the next edge.
